// File: rtl/mem_1r1w_pipe.sv
// Generic 1-read/1-write memory: lane write mask, pipelined read with valid strobe,
// zero-initialisation after reset. Define MEM_1R1W_BYPASS_EN for write-to-read forwarding.
module mem_1r1w_pipe #(
    parameter int unsigned DEPTH        = 48,
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned MASK_GRAN    = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = $clog2(DEPTH),
    parameter int unsigned MASK_W       = WIDTH / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [MASK_W-1:0] W0_mask,
    output logic              init_busy
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_we;
    logic              run;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              w_in_range, r_in_range;
    logic              w_fire, r_fire;
    logic [WIDTH-1:0]  rd_word, rd_next;

    logic [READ_LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]        dat_q [READ_LATENCY];

    // ------------------------------------------------------------------
    // Init / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LastIdx) begin
                    state_d    = StRun;
                    init_cnt_d = '0;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_comb begin
        init_busy = 1'b0;
        init_we   = 1'b0;
        run       = 1'b0;
        unique case (state_q)
            StInit: begin
                init_busy = 1'b1;
                init_we   = 1'b1;
            end
            StRun: begin
                run = 1'b1;
            end
            default: begin
                init_busy = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Array write port
    // ------------------------------------------------------------------
    assign w_in_range = 32'(W0_addr) < DEPTH;
    assign r_in_range = 32'(R0_addr) < DEPTH;
    assign w_fire     = run & W0_en & w_in_range;
    assign r_fire     = run & R0_en;

    always_ff @(posedge clock) begin
        if (init_we) begin
            mem[init_cnt_q] <= '0;
        end else if (w_fire) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (W0_mask[i]) begin
                    mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read sample (stage 0 input)
    // ------------------------------------------------------------------
    assign rd_word = r_in_range ? mem[R0_addr] : '0;

`ifdef MEM_1R1W_BYPASS_EN
    logic [WIDTH-1:0] bit_mask;
    logic             collision;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < MASK_W; i++) begin
            bit_mask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[i]}};
        end
    end

    // w_fire already implies the write address is in range.
    assign collision = w_fire & r_in_range & (W0_addr == R0_addr);
    assign rd_next   = collision ? ((W0_data & bit_mask) | (rd_word & ~bit_mask)) : rd_word;
`else
    // Nonblocking array update makes a same-address read see the old word.
    assign rd_next = rd_word;
`endif

    // ------------------------------------------------------------------
    // Read pipeline; data stages only load behind a valid so the output holds.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= r_fire;
            if (r_fire) begin
                dat_q[0] <= rd_next;
            end
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign R0_valid = vld_q[READ_LATENCY-1];
    assign R0_data  = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_1r1w_pipe.sv
// Self-checking bench for mem_1r1w_pipe (DEPTH=48, WIDTH=64, MASK_GRAN=8, READ_LATENCY=2):
// directed vector table, hand-written reset/init sequences and randomized traffic vs a model.
module tb_mem_1r1w_pipe;

    localparam int unsigned DEPTH = 48;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned GRAN  = 8;
    localparam int unsigned LAT   = 2;
    localparam int unsigned AW    = 6;
    localparam int unsigned MW    = 8;

`ifdef MEM_1R1W_BYPASS_EN
    localparam logic [63:0] COLL_EXP = 64'hDEAD;
`else
    localparam logic [63:0] COLL_EXP = 64'hBEEF;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [AW-1:0]    R0_addr = '0;
    logic             R0_en = 1'b0;
    logic [WIDTH-1:0] R0_data;
    logic             R0_valid;
    logic [AW-1:0]    W0_addr = '0;
    logic             W0_en = 1'b0;
    logic [WIDTH-1:0] W0_data = '0;
    logic [MW-1:0]    W0_mask = '0;
    logic             init_busy;

    mem_1r1w_pipe #(
        .DEPTH       (DEPTH),
        .WIDTH       (WIDTH),
        .MASK_GRAN   (GRAN),
        .READ_LATENCY(LAT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .R0_addr  (R0_addr),
        .R0_en    (R0_en),
        .R0_data  (R0_data),
        .R0_valid (R0_valid),
        .W0_addr  (W0_addr),
        .W0_en    (W0_en),
        .W0_data  (W0_data),
        .W0_mask  (W0_mask),
        .init_busy(init_busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of words, a queue of pending read results with due cycle.
    typedef struct {
        int          due;
        logic [63:0] val;
    } pend_t;

    logic [63:0] mm [DEPTH];
    pend_t       pq [$];
    logic [63:0] last_data;
    int          cyc;
    int          since_rst;

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [63:0] wd;
        logic [7:0]  wm;
        logic        re;
        logic [5:0]  ra;
        logic        ev;
        logic [63:0] ed;
    } vec_t;

    vec_t vt [27];

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int l = 0; l < 8; l++) begin
            if (m[l]) r[l*8 +: 8] = d[l*8 +: 8];
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic we, input logic [5:0] wa, input logic [63:0] wd,
                                input logic [7:0] wm, input logic re, input logic [5:0] ra,
                                input logic ev, input logic [63:0] ed);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.wm = wm;
        v.re = re; v.ra = ra; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) mm[i] = '0;
        pq.delete();
        last_data = '0;
        since_rst = 0;
    endtask

    // Drive one cycle of inputs from a negedge, advance the model at the posedge,
    // check outputs at the following negedge.
    task automatic step(input logic we, input logic [5:0] wa, input logic [63:0] wd,
                        input logic [7:0] wm, input logic re, input logic [5:0] ra);
        logic        busy_now;
        logic [63:0] v;
        logic        exp_v;
        W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
        R0_en = re; R0_addr = ra;
        @(posedge clock);
        cyc++;
        busy_now = since_rst < int'(DEPTH);
        since_rst++;
        if (!busy_now) begin
            if (re) begin
                v = (ra < DEPTH) ? mm[ra] : 64'h0;
`ifdef MEM_1R1W_BYPASS_EN
                if (we && wa == ra && ra < DEPTH) v = merge(v, wd, wm);
`endif
                pq.push_back('{cyc + int'(LAT) - 1, v});
            end
            if (we && wa < DEPTH) mm[wa] = merge(mm[wa], wd, wm);
        end
        @(negedge clock);
        exp_v = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            exp_v     = 1'b1;
            last_data = pq[0].val;
            void'(pq.pop_front());
        end
        check("model_valid", R0_valid, exp_v);
        check("model_data", R0_data, last_data);
        check("model_busy", init_busy, since_rst < int'(DEPTH));
    endtask

    task automatic idle();
        step(1'b0, 6'd0, 64'h0, 8'h00, 1'b0, 6'd0);
    endtask

    // Called at a negedge: asserts reset, checks async clear, releases at next negedge.
    task automatic do_reset();
        reset_n = 1'b0;
        W0_en = 1'b0; R0_en = 1'b0;
        #1;
        check("rst_valid", R0_valid, 1'b0);
        check("rst_data", R0_data, 64'h0);
        check("rst_busy", init_busy, 1'b1);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        int init_valids;
        logic [5:0] wa, ra;

        cyc = 0;
        model_reset();

        vt[0]  = mk(1, 10, 64'h1122334455667788, 8'hFF, 0, 0,  0, 64'h0);
        vt[1]  = mk(1, 10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0,  0, 64'h0);
        vt[2]  = mk(0, 0,  64'h0,                8'h00, 1, 10, 0, 64'h0);
        vt[3]  = mk(0, 0,  64'h0,                8'h00, 0, 0,  1, 64'h11223344AAAAAAAA);
        vt[4]  = mk(1, 0,  64'h100,              8'hFF, 0, 0,  0, 64'h11223344AAAAAAAA);
        vt[5]  = mk(1, 1,  64'h101,              8'hFF, 0, 0,  0, 64'h11223344AAAAAAAA);
        vt[6]  = mk(1, 2,  64'h102,              8'hFF, 0, 0,  0, 64'h11223344AAAAAAAA);
        vt[7]  = mk(1, 3,  64'h103,              8'hFF, 0, 0,  0, 64'h11223344AAAAAAAA);
        vt[8]  = mk(0, 0,  64'h0,                8'h00, 1, 0,  0, 64'h11223344AAAAAAAA);
        vt[9]  = mk(0, 0,  64'h0,                8'h00, 1, 1,  1, 64'h100);
        vt[10] = mk(0, 0,  64'h0,                8'h00, 1, 2,  1, 64'h101);
        vt[11] = mk(0, 0,  64'h0,                8'h00, 1, 3,  1, 64'h102);
        vt[12] = mk(0, 0,  64'h0,                8'h00, 0, 0,  1, 64'h103);
        vt[13] = mk(1, 7,  64'hBEEF,             8'hFF, 0, 0,  0, 64'h103);
        vt[14] = mk(1, 7,  64'hDEAD,             8'hFF, 1, 7,  0, 64'h103);
        vt[15] = mk(0, 0,  64'h0,                8'h00, 0, 0,  1, COLL_EXP);
        vt[16] = mk(0, 0,  64'h0,                8'h00, 1, 7,  0, COLL_EXP);
        vt[17] = mk(1, 50, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 0,  1, 64'hDEAD);
        vt[18] = mk(0, 0,  64'h0,                8'h00, 1, 50, 0, 64'hDEAD);
        vt[19] = mk(0, 0,  64'h0,                8'h00, 0, 0,  1, 64'h0);
        vt[20] = mk(0, 0,  64'h0,                8'h00, 1, 47, 0, 64'h0);
        vt[21] = mk(0, 0,  64'h0,                8'h00, 0, 0,  1, 64'h0);
        vt[22] = mk(0, 0,  64'h0,                8'h00, 1, 2,  0, 64'h0);
        vt[23] = mk(0, 0,  64'h0,                8'h00, 0, 0,  1, 64'h102);
        vt[24] = mk(1, 5,  64'h55,               8'h00, 0, 0,  0, 64'h102);
        vt[25] = mk(0, 0,  64'h0,                8'h00, 1, 5,  0, 64'h102);
        vt[26] = mk(0, 0,  64'h0,                8'h00, 0, 0,  1, 64'h0);

        // Power-on reset, then init with a read held on addr 5 throughout.
        @(negedge clock);
        do_reset();
        busy_cnt    = 0;
        init_valids = 0;
        if (init_busy === 1'b1) busy_cnt++;
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd5);
            if (init_busy === 1'b1) busy_cnt++;
            if (R0_valid !== 1'b0) init_valids++;
        end
        check("init_busy_cycles", 64'(busy_cnt), 64'd48);
        check("init_no_valid", 64'(init_valids), 64'd0);
        step(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd5);
        check("first_read_pending", R0_valid, 1'b0);
        idle();
        check("first_read_valid", R0_valid, 1'b1);
        check("first_read_data", R0_data, 64'h0);
        idle();
        idle();

        // Directed vector table.
        foreach (vt[i]) begin
            step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].wm, vt[i].re, vt[i].ra);
            check($sformatf("vec%0d_valid", i), R0_valid, vt[i].ev);
            check($sformatf("vec%0d_data", i), R0_data, vt[i].ed);
        end

        // Randomized traffic including out-of-range addresses and collisions.
        for (int i = 0; i < 800; i++) begin
            wa = 6'($urandom_range(0, 55));
            ra = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 55));
            step(1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, 8'($urandom),
                 1'($urandom_range(0, 1)), ra);
        end
        // Sweep every entry so out-of-range writes that aliased would show.
        for (int a = 0; a < int'(DEPTH); a++) step(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'(a));
        idle();
        idle();

        // Reset mid-init at count 20, then reset with two reads in flight.
        do_reset();
        for (int i = 0; i < 20; i++) idle();
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) idle();
        check("reinit_done", init_busy, 1'b0);
        step(1'b1, 6'd10, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 6'd0);
        step(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd10);
        step(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd10);
        check("inflight_valid_before_rst", R0_valid, 1'b1);
        check("inflight_data_before_rst", R0_data, 64'h0123456789ABCDEF);
        do_reset();
        busy_cnt = 0;
        if (init_busy === 1'b1) busy_cnt++;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idle();
            if (init_busy === 1'b1) busy_cnt++;
        end
        check("reinit_busy_cycles", 64'(busy_cnt), 64'd48);
        step(1'b0, 6'd0, 64'h0, 8'h00, 1'b1, 6'd10);
        idle();
        check("cleared_addr10_valid", R0_valid, 1'b1);
        check("cleared_addr10_data", R0_data, 64'h0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_1r1w_pipe.md
Name: mem_1r1w_pipe

Overview:
Parametrised single-clock 1-read/1-write memory. It adds four things a plain RAM macro wrapper lacks:
- per-lane write mask
- configurable registered read latency with a read-valid strobe
- hardware zero-initialisation after reset
- defined same-address read/write collision behaviour

It sits under the lowered Chisel memories as the generic (non-vendor) implementation for queues, register files and tag arrays.

Parameters:
DEPTH, 48, number of entries; any value >= 2, not necessarily a power of two.
WIDTH, 64, data bits per entry.
MASK_GRAN, 8, bits per write-mask lane; WIDTH % MASK_GRAN == 0; MASK_GRAN == WIDTH gives an unmasked memory.
READ_LATENCY, 1, cycles from R0_en to R0_valid; legal range 1..4.
ADDR_W, clog2(DEPTH), address width (derived).
MASK_W, WIDTH/MASK_GRAN, mask lanes (derived).

Ports:
clock  input  1  single clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
R0_addr  input  ADDR_W  read address.
R0_en  input  1  read request, sampled each cycle.
R0_data  output  WIDTH  read data.
R0_valid  output  1  R0_data holds the result of a read.
W0_addr  input  ADDR_W  write address.
W0_en  input  1  write request.
W0_data  input  WIDTH  write data.
W0_mask  input  MASK_W  lane enables; bit i covers data bits [i*MASK_GRAN +: MASK_GRAN].
init_busy  output  1  zero-initialisation in progress.

Behaviour:
- Reset values:
  - init_busy = 1, R0_valid = 0, R0_data = 0.
  - All read-pipeline valid/data stages = 0; FSM = INIT, init counter = 0.
  - Array contents are not reset directly; they are cleared by the FSM.
- FSM state INIT:
  - One entry per cycle, counter 0..DEPTH-1, writes all-zero to the entry.
  - R0_en and W0_en are ignored; no read valid is generated.
  - After the cycle that writes DEPTH-1, go to RUN. init_busy falls on the first RUN cycle, exactly DEPTH cycles after reset release.
- FSM state RUN:
  - RUN is terminal until reset.
  - reset_n asserted in any state, including mid-INIT or with reads in flight: all in-flight reads are dropped (valids cleared) and INIT restarts from entry 0.
- Write (RUN, W0_en=1):
  - At the clock edge, lane i of entry W0_addr takes W0_data lane i where W0_mask[i]=1; other lanes are unchanged.
  - W0_mask = 0 is a legal no-op.
- Read (RUN, R0_en=1 at edge t):
  - The array is sampled at edge t. R0_data is driven and R0_valid=1 for exactly one cycle after edge t+READ_LATENCY-1; READ_LATENCY=1 means the result is visible in the cycle after the request.
  - Back-to-back reads are fully pipelined: one result per cycle, in order, no stalls.
  - R0_data holds its last value while R0_valid=0.
- Out-of-range address (addr >= DEPTH): the write is dropped; the read returns 0 with R0_valid=1.
- Same-address read and write in the same cycle: the read returns the pre-write contents for every lane (read-first), unless MEM_1R1W_BYPASS_EN is defined.
- No combinational path exists from any input to R0_data or R0_valid.

Optional Feature:
MEM_1R1W_BYPASS_EN:
- Defined: on a same-address collision in RUN, the read result is the merged write result. Lanes with W0_mask=1 come from W0_data; the rest come from the old contents. The forwarded value enters pipeline stage 0 and has the same latency as any read.
- Undefined: read-first as above. No forwarding mux or address comparator is built.

Test Plan:
Parameters for all scenarios: DEPTH=48, WIDTH=64, MASK_GRAN=8, READ_LATENCY=2 unless noted.
1. Release reset, hold R0_en=1 at addr 5 throughout → init_busy=1 for exactly 48 cycles, no R0_valid during INIT; first read returns 0x0 with R0_valid two cycles after the first RUN-cycle request.
2. Write 0x1122334455667788 mask 0xFF to addr 10, then write 0xAAAAAAAAAAAAAAAA mask 0x0F to addr 10, then read addr 10 → 0x11223344AAAAAAAA.
3. Read addrs 0,1,2,3 on consecutive cycles after writing value = addr+0x100 → R0_valid high 4 consecutive cycles with data 0x100..0x103 in order, starting 2 cycles after the first request.
4. Write 0xDEAD mask 0xFF and read addr 7 (holding 0xBEEF) in the same cycle → 0xBEEF without the macro; 0xDEAD with MEM_1R1W_BYPASS_EN.
5. Write to addr 50, read addr 50 → R0_data=0, R0_valid=1; entries 0..47 unchanged.
6. Assert reset_n=0 at INIT count 20 and again with 2 reads in flight → valids drop immediately, R0_data=0, init_busy=1, full 48-cycle clear repeats and previously written addr 10 reads 0.
